// File: rtl/k_vector_loader_pkg.sv
// k_vector_loader_pkg: shared sizes and types for the K-vector load path.
//   MAX_SEQ_LENGTH : K FIFO depth, i.e. the largest number of vectors per load
//   MEM_WORD_T     : one external-memory data word
//   K_VECTOR_T     : one assembled K vector (an exact multiple of MEM_WORD_W)
package k_vector_loader_pkg;
    localparam int MAX_SEQ_LENGTH = 8;
    localparam int MEM_WORD_W     = 64;
    localparam int K_VECTOR_W     = 256;
    typedef logic [MEM_WORD_W-1:0] MEM_WORD_T;
    typedef logic [K_VECTOR_W-1:0] K_VECTOR_T;
endpackage

// File: rtl/k_vector_loader_if.sv
// k_vector_loader_if: command, memory-read and K-FIFO write bundle of the loader.
//   command : start, base_addr, seq_len -> busy, done
//   mem read: mem_req_valid/addr -> mem_req_ready; mem_resp_valid/data (in order, no backpressure)
//   K FIFO  : write_enable/write_data -> sram_ready
//   master = loader side, slave = controller/memory/FIFO side
interface k_vector_loader_if
    import k_vector_loader_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = $clog2(MAX_SEQ_LENGTH) + 1
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  seq_len;
    logic              busy;
    logic              done;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    MEM_WORD_T         mem_resp_data;
    logic              write_enable;
    K_VECTOR_T         write_data;
    logic              sram_ready;

    modport master (
        input  start, base_addr, seq_len, mem_req_ready, mem_resp_valid, mem_resp_data, sram_ready,
        output busy, done, mem_req_valid, mem_req_addr, write_enable, write_data
    );
    modport slave (
        output start, base_addr, seq_len, mem_req_ready, mem_resp_valid, mem_resp_data, sram_ready,
        input  busy, done, mem_req_valid, mem_req_addr, write_enable, write_data
    );
endinterface

// File: rtl/k_vector_loader.sv
// k_vector_loader: fetches seq_len K vectors word by word from memory and pushes each into the K FIFO.
//   clk, rst : clock, synchronous active-high reset
//   io_kv    : master side of k_vector_loader_if (command, memory read port, K FIFO write port)
module k_vector_loader
    import k_vector_loader_pkg::*;
#(
    parameter int NUM_ENTRIES   = MAX_SEQ_LENGTH,
    parameter int MEM_W         = MEM_WORD_W,
    parameter int WORDS_PER_VEC = $bits(K_VECTOR_T) / MEM_W,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    k_vector_loader_if.master io_kv
);
    localparam int LEN_W = $clog2(NUM_ENTRIES) + 1;
    localparam int CNT_W = $clog2(WORDS_PER_VEC) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, PUSH, DONE} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len, r_row, w_len;
    logic [CNT_W-1:0]  r_req_cnt, r_resp_cnt;
    K_VECTOR_T         r_vec;
    logic              w_start, w_req_fire, w_resp, w_last_resp, w_push, w_last_row;

    assign w_len       = (io_kv.seq_len > LEN_W'(NUM_ENTRIES)) ? LEN_W'(NUM_ENTRIES) : io_kv.seq_len;
    assign w_start     = r_state == IDLE && io_kv.start;
    assign w_req_fire  = io_kv.mem_req_valid && io_kv.mem_req_ready;
    // responses outside FETCH are dropped without touching any counter
    assign w_resp      = r_state == FETCH && io_kv.mem_resp_valid;
    assign w_last_resp = w_resp && r_resp_cnt == CNT_W'(WORDS_PER_VEC - 1);
    assign w_push      = r_state == PUSH && io_kv.sram_ready;
    assign w_last_row  = r_row == r_len - LEN_W'(1);

    assign io_kv.busy          = r_state != IDLE;
    assign io_kv.done          = r_state == DONE;
    // request count per vector is capped, so outstanding reads never exceed one vector
    assign io_kv.mem_req_valid = r_state == FETCH && r_req_cnt < CNT_W'(WORDS_PER_VEC);
    assign io_kv.mem_req_addr  = (r_state == FETCH)
                               ? r_base + ADDR_W'(r_row) * ADDR_W'(WORDS_PER_VEC) + ADDR_W'(r_req_cnt)
                               : '0;
    assign io_kv.write_enable  = r_state == PUSH;
    assign io_kv.write_data    = r_vec;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? ((w_len == '0) ? DONE : FETCH) : IDLE;
            FETCH:   w_next = w_last_resp ? PUSH : FETCH;
            PUSH:    w_next = w_push ? (w_last_row ? DONE : FETCH) : PUSH;
            default: w_next = IDLE;
        endcase
    end

    // start, push and fetch activity are mutually exclusive by state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_len      <= '0;
            r_row      <= '0;
            r_req_cnt  <= '0;
            r_resp_cnt <= '0;
            r_vec      <= '0;
        end else if (w_start) begin
            r_base     <= io_kv.base_addr;
            r_len      <= w_len;
            r_row      <= '0;
            r_req_cnt  <= '0;
            r_resp_cnt <= '0;
        end else if (w_push && !w_last_row) begin
            r_row      <= r_row + 1'b1;
            r_req_cnt  <= '0;
            r_resp_cnt <= '0;
        end else begin
            if (w_req_fire) r_req_cnt <= r_req_cnt + 1'b1;
            if (w_resp) begin
                r_resp_cnt <= r_resp_cnt + 1'b1;
                for (int i = 0; i < WORDS_PER_VEC; i++)
                    if (r_resp_cnt == CNT_W'(i)) r_vec[i*MEM_W +: MEM_W] <= io_kv.mem_resp_data;
            end
        end
    end
endmodule
